// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the registered ALU control sequencer (alu_ctrl_seq).
// Imported by the decoder and the sequencer top.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        ALU_OP_ADD = 2'b00,
        ALU_OP_SUB = 2'b01,
        ALU_OP_R   = 2'b10,
        ALU_OP_RMC = 2'b11
    } alu_op_e;

    localparam int unsigned ALU_CNT_ADD = 0;
    localparam int unsigned ALU_CNT_SUB = 1;

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        MULTI
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational {alu_op, opcode} -> {alu_cnt, illegal, is_multi} decoder.
// Out-of-range R-type function codes decode to ADD, flag illegal and never go multi-cycle.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OPC_W = 4,
    parameter int CNT_W = 3
) (
    input  logic [1:0]       alu_op,
    input  logic [OPC_W-1:0] opcode,
    output logic [CNT_W-1:0] alu_cnt,
    output logic             illegal,
    output logic             is_multi
);

    logic in_range;

    // Legal iff no bit at or above CNT_W is set.
    assign in_range = (opcode >> CNT_W) == '0;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        alu_cnt  = '0;
        illegal  = 1'b0;
        is_multi = 1'b0;
        case (alu_op)
            ALU_OP_ADD: alu_cnt = CNT_W'(ALU_CNT_ADD);
            ALU_OP_SUB: alu_cnt = CNT_W'(ALU_CNT_SUB);
            default: begin
                if (in_range) begin
                    alu_cnt  = opcode[CNT_W-1:0];
                    is_multi = (alu_op == ALU_OP_RMC);
                end else begin
                    illegal = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control sequencer: valid/ready request in, one or MC_CYCLES control beats out.
// Optional build macro ALU_CTRL_PERF_EN adds saturating perf_ops / perf_illegal counters.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter  int OPC_W     = 4,
    parameter  int CNT_W     = 3,
    parameter  int MC_CYCLES = 4,
    localparam int STEP_W    = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [OPC_W-1:0]  opcode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  alu_cnt,
    output logic [STEP_W-1:0] alu_step,
    output logic              alu_last,
    output logic              illegal
`ifdef ALU_CTRL_PERF_EN
    ,
    output logic [15:0]       perf_ops,
    output logic [15:0]       perf_illegal
`endif
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MC_CYCLES - 1);
    localparam bit                MC_EN     = (MC_CYCLES > 1);

    state_e            state;
    logic [CNT_W-1:0]  dec_cnt;
    logic              dec_illegal;
    logic              dec_multi;
    logic              accept;
    logic              advance;
    logic              fire_last;
    logic [STEP_W-1:0] next_step;

    alu_ctrl_decode #(
        .OPC_W (OPC_W),
        .CNT_W (CNT_W)
    ) u_decode (
        .alu_op   (alu_op),
        .opcode   (opcode),
        .alu_cnt  (dec_cnt),
        .illegal  (dec_illegal),
        .is_multi (dec_multi)
    );

    // A new request may only land when the current op retires this cycle.
    assign in_ready  = (state == IDLE)
                     | ((state == SINGLE) & out_ready)
                     | ((state == MULTI) & out_ready & alu_last);
    assign accept    = in_valid & in_ready;
    assign advance   = (state == MULTI) & out_ready & ~alu_last;
    assign fire_last = out_valid & out_ready & alu_last;
    assign next_step = alu_step + STEP_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            alu_cnt   <= '0;
            alu_step  <= '0;
            alu_last  <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments so every register here sees pre-edge values.
            out_valid <= 1'b1;
            alu_cnt   <= dec_cnt;
            illegal   <= dec_illegal;
            alu_step  <= '0;
            if (dec_multi && MC_EN) begin
                state    <= MULTI;
                alu_last <= 1'b0;
            end else begin
                state    <= SINGLE;
                alu_last <= 1'b1;
            end
        end else if (advance) begin
            alu_step <= next_step;
            alu_last <= (next_step == LAST_STEP);
        end else if (fire_last) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            alu_last  <= 1'b0;
        end
    end

`ifdef ALU_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops     <= '0;
            perf_illegal <= '0;
        end else if (fire_last) begin
            if (perf_ops != 16'hFFFF)
                perf_ops <= perf_ops + 16'd1;
            if (illegal && perf_illegal != 16'hFFFF)
                perf_illegal <= perf_illegal + 16'd1;
        end
    end
`else
    // Default build carries no performance counters.
`endif

endmodule
